uart_param_core: RTL and testbench
==================================

// Module: uart_param_core
// PURPOSE
//   Parametrised full-duplex UART core for the gamepad/PSone serial path. Configurable
//   word length, stop bits, oversampling and baud divider. TX side: valid/ready byte
//   handshake. RX side: 2-FF input synchroniser, mid-bit sampling, first-word-fall-through
//   receive FIFO, framing and overrun reporting. Sits between the pad protocol engines
//   and the external serial pins.
// PARAMETERS
//   CLK_DIV     1302  iCLK cycles per oversample tick (>=2)
//   OVERSAMPLE  4     ticks per bit period (even, 4..16)
//   DATA_BITS   8     data bits per frame (5..9), LSB first
//   STOP_BITS   1     stop bits transmitted (1 or 2); RX checks only the first
//   FIFO_AW     2     RX FIFO address width; depth = 2**FIFO_AW
// PORTS
//   iCLK         in   1          system clock
//   iRESET       in   1          synchronous reset, active-low
//   iRX          in   1          serial input (asynchronous)
//   oTX          out  1          serial output, idle high
//   iTX_VALID    in   1          TX word offered
//   iTX_DATA     in   DATA_BITS  TX word
//   oTX_READY    out  1          TX accepts a word this cycle
//   oRX_VALID    out  1          RX FIFO not empty
//   oRX_DATA     out  DATA_BITS  RX FIFO head word (FWFT)
//   iRX_POP      in   1          consume head word; ignored when oRX_VALID=0
//   oRX_COUNT    out  FIFO_AW+1  words held in RX FIFO
//   oFRAME_ERR   out  1          1-cycle pulse: stop bit sampled low
//   oOVERRUN     out  1          sticky: word dropped, FIFO full
//   iERR_CLR     in   1          clears oOVERRUN (and sticky parity flag)
// BEHAVIOUR
//   Reset (iRESET=0 at posedge): oTX=1, oTX_READY=1, FIFO emptied (oRX_VALID=0,
//     oRX_COUNT=0, oRX_DATA=0), oFRAME_ERR=0, oOVERRUN=0, both FSMs IDLE, dividers
//     reloaded. Reset mid-frame aborts the frame; oTX high the cycle after reset.
//   Bit period T = CLK_DIV*OVERSAMPLE cycles, exact, no cumulative drift.
//   TX FSM IDLE->START->DATA->[PARITY]->STOP->IDLE:
//     - Accept when iTX_VALID & oTX_READY; oTX_READY=0 from the next cycle.
//     - oTX low the cycle after acceptance for T; then data LSB first, T each;
//       then STOP_BITS*T high; oTX_READY=1 on the cycle after the last stop bit ends.
//     - iTX_DATA sampled only at acceptance; changes afterwards are ignored.
//   RX FSM IDLE->START->DATA->[PARITY]->STOP->(PUSH|ERR)->IDLE:
//     - Synchronised line (2 FFs, +2 cycle latency). Falling edge in IDLE restarts RX
//       tick divider; line sampled at OVERSAMPLE/2 ticks (start), then every
//       OVERSAMPLE ticks.
//     - Start sample high: false start, return to IDLE, no flag.
//     - Stop sample high: push word. Stop low: oFRAME_ERR pulse, word discarded, FSM
//       waits for line high before IDLE (no new start detected while low).
//   RX FIFO: write pointer/read pointer FIFO_AW+1 bits, wrap at 2**FIFO_AW.
//     - Push when full and no pop: word dropped, oOVERRUN=1 until iERR_CLR or reset.
//     - Push and pop same cycle when full: both occur, count unchanged, no overrun.
//     - Pop when empty: no effect. iERR_CLR concurrent with new overrun: set wins.
// CONFIGURATION
//   UART_PARITY_EN defined: adds input iPARITY_ODD (1=odd, 0=even, sampled at TX accept
//   / RX start) and output oPARITY_ERR (sticky, cleared by iERR_CLR). One parity bit
//   (T) after data on TX; RX checks it, word with bad parity still pushed, flag set.
//   Undefined: no parity bit, ports absent, frame = 1+DATA_BITS+STOP_BITS bits.
// TESTING (CLK_DIV=4, OVERSAMPLE=4 -> T=16 cycles unless stated)
//   TX 8'hA5, STOP_BITS=1 -> oTX low 16 cyc, then 1,0,1,0,0,1,0,1 x16 cyc each,
//     high 16; oTX_READY low for exactly 160 cycles.
//   Loop oTX->iRX, send 8'h00,8'hFF,8'h5A -> oRX_COUNT=3, pops return same order.
//   RX frame with stop bit low (8'h3C) -> oFRAME_ERR 1-cycle pulse, oRX_COUNT unchanged;
//     next good frame 8'h81 received.
//   FIFO_AW=2: 5 frames, no pops -> oRX_COUNT=4, oOVERRUN=1, head = first word;
//     iERR_CLR -> 0. 8-cycle low glitch on iRX -> nothing received, no error.
//   Reset asserted mid-TX data bit 3 -> oTX=1, oTX_READY=1 next cycle; FIFO empty.
//   UART_PARITY_EN, odd, TX 8'h01 -> parity bit 0; RX with flipped parity
//     -> word pushed, oPARITY_ERR=1.

Source files
------------

// File: rtl/uart_param_core_if.sv
// uart_param_core_if: serial pins, TX handshake and RX FIFO/status bundle for uart_param_core.
// Parity signals exist only when UART_PARITY_EN is defined.
interface uart_param_core_if #(
    parameter int DATA_BITS = 8,
    parameter int FIFO_AW   = 2
);
    logic                 iRX;
    logic                 oTX;
    logic                 iTX_VALID;
    logic [DATA_BITS-1:0] iTX_DATA;
    logic                 oTX_READY;
    logic                 oRX_VALID;
    logic [DATA_BITS-1:0] oRX_DATA;
    logic                 iRX_POP;
    logic [FIFO_AW:0]     oRX_COUNT;
    logic                 oFRAME_ERR;
    logic                 oOVERRUN;
    logic                 iERR_CLR;
`ifdef UART_PARITY_EN
    logic                 iPARITY_ODD;
    logic                 oPARITY_ERR;
`endif

    modport slave (
        input  iRX, iTX_VALID, iTX_DATA, iRX_POP, iERR_CLR,
        output oTX, oTX_READY, oRX_VALID, oRX_DATA, oRX_COUNT, oFRAME_ERR, oOVERRUN
`ifdef UART_PARITY_EN
        , input iPARITY_ODD, output oPARITY_ERR
`endif
    );

    modport master (
        output iRX, iTX_VALID, iTX_DATA, iRX_POP, iERR_CLR,
        input  oTX, oTX_READY, oRX_VALID, oRX_DATA, oRX_COUNT, oFRAME_ERR, oOVERRUN
`ifdef UART_PARITY_EN
        , output iPARITY_ODD, input oPARITY_ERR
`endif
    );
endinterface

// File: rtl/uart_param_core.sv
// uart_param_core: full-duplex UART with valid/ready TX, mid-bit sampling RX and FWFT RX FIFO.
// Define UART_PARITY_EN to add a parity bit (iPARITY_ODD / oPARITY_ERR).
module uart_param_core #(
    parameter int CLK_DIV    = 1302,
    parameter int OVERSAMPLE = 4,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_AW    = 2
) (
    input logic               iCLK,
    input logic               iRESET,
    uart_param_core_if.slave  bus
);
    localparam int T  = CLK_DIV * OVERSAMPLE;
    localparam int H  = CLK_DIV * (OVERSAMPLE / 2);
    localparam int CW = $clog2(T);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT} state_t;

`ifdef UART_PARITY_EN
    localparam state_t POST_DATA = PARITY;
`else
    localparam state_t POST_DATA = STOP;
`endif

    state_t               tx_st, tx_st_n;
    logic [CW-1:0]        tx_cnt, tx_cnt_n;
    logic [3:0]           tx_bit, tx_bit_n;
    logic [DATA_BITS-1:0] tx_sh, tx_sh_n;
    logic                 tx_line, tx_line_n, tx_end;

`ifdef UART_PARITY_EN
    logic tx_par;
    always_ff @(posedge iCLK)
        if (!iRESET) tx_par <= 1'b0;
        else if (tx_st == IDLE && bus.iTX_VALID) tx_par <= ^bus.iTX_DATA ^ bus.iPARITY_ODD;
`else
    localparam logic tx_par = 1'b1;
`endif

    always_ff @(posedge iCLK) begin
        if (!iRESET) begin
            tx_st   <= IDLE;
            tx_cnt  <= '0;
            tx_bit  <= '0;
            tx_sh   <= '0;
            tx_line <= 1'b1;
        end else begin
            tx_st   <= tx_st_n;
            tx_cnt  <= tx_cnt_n;
            tx_bit  <= tx_bit_n;
            tx_sh   <= tx_sh_n;
            tx_line <= tx_line_n;
        end
    end

    // Line level is registered from the next state so oTX changes exactly on bit boundaries.
    always_comb begin
        tx_st_n  = tx_st;
        tx_cnt_n = tx_cnt + 1'b1;
        tx_bit_n = tx_bit;
        tx_sh_n  = tx_sh;
        tx_end   = tx_cnt == CW'(T - 1);
        case (tx_st)
            IDLE: begin
                tx_cnt_n = '0;
                tx_bit_n = '0;
                if (bus.iTX_VALID) begin
                    tx_st_n = START;
                    tx_sh_n = bus.iTX_DATA;
                end
            end
            START: if (tx_end) begin
                tx_st_n  = DATA;
                tx_cnt_n = '0;
            end
            DATA: if (tx_end) begin
                tx_cnt_n = '0;
                tx_sh_n  = tx_sh >> 1;
                tx_bit_n = tx_bit + 1'b1;
                if (tx_bit == 4'(DATA_BITS - 1)) begin
                    tx_bit_n = '0;
                    tx_st_n  = POST_DATA;
                end
            end
            PARITY: if (tx_end) begin
                tx_cnt_n = '0;
                tx_st_n  = STOP;
            end
            STOP: if (tx_end) begin
                tx_cnt_n = '0;
                tx_bit_n = tx_bit + 1'b1;
                if (tx_bit == 4'(STOP_BITS - 1)) tx_st_n = IDLE;
            end
            default: tx_st_n = IDLE;
        endcase
        tx_line_n = tx_st_n == START ? 1'b0 : tx_st_n == DATA ? tx_sh_n[0] : tx_st_n == PARITY ? tx_par : 1'b1;
    end

    assign bus.oTX       = tx_line;
    assign bus.oTX_READY = tx_st == IDLE;

    logic                 rx_s1, rx_s2, rx_s3;
    state_t               rx_st, rx_st_n;
    logic [CW-1:0]        rx_cnt, rx_cnt_n;
    logic [3:0]           rx_bit, rx_bit_n;
    logic [DATA_BITS-1:0] rx_sh, rx_sh_n;
    logic                 rx_end, push, ferr, ferr_q;

`ifdef UART_PARITY_EN
    logic rx_odd, par_bad, par_err;
`endif

    always_ff @(posedge iCLK) begin
        if (!iRESET) begin
            {rx_s1, rx_s2, rx_s3} <= 3'b111;
            rx_st  <= IDLE;
            rx_cnt <= '0;
            rx_bit <= '0;
            rx_sh  <= '0;
            ferr_q <= 1'b0;
        end else begin
            {rx_s1, rx_s2, rx_s3} <= {bus.iRX, rx_s1, rx_s2};
            rx_st  <= rx_st_n;
            rx_cnt <= rx_cnt_n;
            rx_bit <= rx_bit_n;
            rx_sh  <= rx_sh_n;
            ferr_q <= ferr;
        end
    end

    // Start is checked half a bit after the falling edge; later samples are one bit apart.
    always_comb begin
        rx_st_n  = rx_st;
        rx_cnt_n = rx_cnt + 1'b1;
        rx_bit_n = rx_bit;
        rx_sh_n  = rx_sh;
        push     = 1'b0;
        ferr     = 1'b0;
`ifdef UART_PARITY_EN
        par_bad  = 1'b0;
`endif
        rx_end   = rx_cnt == CW'(T - 1);
        case (rx_st)
            IDLE: begin
                rx_cnt_n = '0;
                rx_bit_n = '0;
                if (!rx_s2 && rx_s3) rx_st_n = START;
            end
            START: if (rx_cnt == CW'(H - 1)) begin
                rx_cnt_n = '0;
                rx_st_n  = rx_s2 ? IDLE : DATA;
            end
            DATA: if (rx_end) begin
                rx_cnt_n = '0;
                rx_sh_n  = {rx_s2, rx_sh[DATA_BITS-1:1]};
                rx_bit_n = rx_bit + 1'b1;
                if (rx_bit == 4'(DATA_BITS - 1)) rx_st_n = POST_DATA;
            end
`ifdef UART_PARITY_EN
            PARITY: if (rx_end) begin
                rx_cnt_n = '0;
                par_bad  = rx_s2 != (^rx_sh ^ rx_odd);
                rx_st_n  = STOP;
            end
`endif
            STOP: if (rx_end) begin
                push    = rx_s2;
                ferr    = !rx_s2;
                rx_st_n = rx_s2 ? IDLE : WAIT;
            end
            WAIT: if (rx_s2) rx_st_n = IDLE;
            default: rx_st_n = IDLE;
        endcase
    end

`ifdef UART_PARITY_EN
    always_ff @(posedge iCLK) begin
        if (!iRESET) begin
            rx_odd  <= 1'b0;
            par_err <= 1'b0;
        end else begin
            if (rx_st == IDLE && !rx_s2 && rx_s3) rx_odd <= bus.iPARITY_ODD;
            if (par_bad) par_err <= 1'b1;
            else if (bus.iERR_CLR) par_err <= 1'b0;
        end
    end
    assign bus.oPARITY_ERR = par_err;
`endif

    logic [DATA_BITS-1:0] mem [2**FIFO_AW];
    logic [FIFO_AW:0]     wp, rp, cnt;
    logic                 full, empty, do_pop, do_push, ovr;

    assign cnt     = wp - rp;
    assign full    = cnt[FIFO_AW];
    assign empty   = cnt == '0;
    assign do_pop  = bus.iRX_POP && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge iCLK)
        if (do_push) mem[wp[FIFO_AW-1:0]] <= rx_sh;

    always_ff @(posedge iCLK) begin
        if (!iRESET) begin
            wp  <= '0;
            rp  <= '0;
            ovr <= 1'b0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop) rp <= rp + 1'b1;
            if (push && full && !do_pop) ovr <= 1'b1;
            else if (bus.iERR_CLR) ovr <= 1'b0;
        end
    end

    assign bus.oRX_VALID  = !empty;
    assign bus.oRX_DATA   = empty ? '0 : mem[rp[FIFO_AW-1:0]];
    assign bus.oRX_COUNT  = cnt;
    assign bus.oFRAME_ERR = ferr_q;
    assign bus.oOVERRUN   = ovr;
endmodule

// File: tb/tb_uart_param_core.sv
// tb_uart_param_core: directed checks of uart_param_core with T = 16 cycles.
module tb_uart_param_core;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic loop = 1'b0;
    logic rx_drv = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   fe_cyc = 0;
    int   fe_base;
    int   rl;
    logic tr [170];
    logic [9:0] fr;

    always #5 clk = ~clk;

    uart_param_core_if #(.DATA_BITS(8), .FIFO_AW(2)) bus();
    assign bus.iRX = loop ? bus.oTX : rx_drv;

    uart_param_core #(.CLK_DIV(4), .OVERSAMPLE(4), .DATA_BITS(8), .STOP_BITS(1), .FIFO_AW(2)) dut (
        .iCLK(clk), .iRESET(rst_n), .bus(bus)
    );

    always @(posedge clk) if (bus.oFRAME_ERR) fe_cyc <= fe_cyc + 1;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_tx(input logic [7:0] d);
        int n = 0;
        @(negedge clk);
        while (!bus.oTX_READY && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("tx_ready_wait", bus.oTX_READY, 1);
        bus.iTX_VALID = 1'b1;
        bus.iTX_DATA  = d;
        @(negedge clk);
        bus.iTX_VALID = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] d, input logic stop);
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = d[i];
            repeat (16) @(negedge clk);
        end
        rx_drv = stop;
        repeat (16) @(negedge clk);
        rx_drv = 1'b1;
        repeat (16) @(negedge clk);
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] exp);
        check(tag, bus.oRX_DATA, exp);
        bus.iRX_POP = 1'b1;
        @(negedge clk);
        bus.iRX_POP = 1'b0;
    endtask

    initial begin
        bus.iTX_VALID = 1'b0;
        bus.iTX_DATA  = '0;
        bus.iRX_POP   = 1'b0;
        bus.iERR_CLR  = 1'b0;
`ifdef UART_PARITY_EN
        bus.iPARITY_ODD = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_tx", bus.oTX, 1);
        check("rst_ready", bus.oTX_READY, 1);
        check("rst_valid", bus.oRX_VALID, 0);
        check("rst_count", bus.oRX_COUNT, 0);
        check("rst_data", bus.oRX_DATA, 0);
        check("rst_ferr", bus.oFRAME_ERR, 0);
        check("rst_ovr", bus.oOVERRUN, 0);
        rst_n = 1'b1;

        // TX waveform of 8'hA5; data input changed right after acceptance
        send_tx(8'hA5);
        bus.iTX_DATA = 8'hFF;
        rl = 0;
        for (int i = 0; i < 170; i++) begin
            tr[i] = bus.oTX;
            if (!bus.oTX_READY) rl++;
            @(negedge clk);
        end
        fr = {1'b1, 8'hA5, 1'b0};
        for (int b = 0; b < 10; b++) begin
            check($sformatf("tx_bit%0d_first", b), tr[16*b], fr[b]);
            check($sformatf("tx_bit%0d_last", b), tr[16*b+15], fr[b]);
        end
        check("tx_ready_low_cycles", rl, 160);
        check("tx_idle_after", tr[160], 1);

        // loopback of three words
        loop = 1'b1;
        send_tx(8'h00);
        send_tx(8'hFF);
        send_tx(8'h5A);
        repeat (200) @(negedge clk);
        check("loop_count", bus.oRX_COUNT, 3);
        pop_chk("loop_w0", 8'h00);
        pop_chk("loop_w1", 8'hFF);
        pop_chk("loop_w2", 8'h5A);
        check("loop_empty_count", bus.oRX_COUNT, 0);
        check("loop_empty_valid", bus.oRX_VALID, 0);
        loop = 1'b0;

        // framing error then a good frame
        fe_base = fe_cyc;
        send_rx(8'h3C, 1'b0);
        check("ferr_pulse_cycles", fe_cyc - fe_base, 1);
        check("ferr_count", bus.oRX_COUNT, 0);
        send_rx(8'h81, 1'b1);
        check("after_ferr_count", bus.oRX_COUNT, 1);
        pop_chk("after_ferr_word", 8'h81);
        check("after_ferr_no_flag", fe_cyc - fe_base, 1);

        // overrun with five frames and no pops
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        send_rx(8'h33, 1'b1);
        send_rx(8'h44, 1'b1);
        check("ovr_not_yet", bus.oOVERRUN, 0);
        send_rx(8'h55, 1'b1);
        check("ovr_count", bus.oRX_COUNT, 4);
        check("ovr_flag", bus.oOVERRUN, 1);
        check("ovr_head", bus.oRX_DATA, 8'h11);
        bus.iERR_CLR = 1'b1;
        @(negedge clk);
        bus.iERR_CLR = 1'b0;
        check("ovr_cleared", bus.oOVERRUN, 0);
        pop_chk("ovr_w0", 8'h11);
        pop_chk("ovr_w1", 8'h22);
        pop_chk("ovr_w2", 8'h33);
        pop_chk("ovr_w3", 8'h44);
        check("ovr_drained", bus.oRX_COUNT, 0);
        bus.iRX_POP = 1'b1;
        @(negedge clk);
        bus.iRX_POP = 1'b0;
        check("pop_empty_count", bus.oRX_COUNT, 0);

        // 8-cycle glitch is a false start
        fe_base = fe_cyc;
        rx_drv = 1'b0;
        repeat (8) @(negedge clk);
        rx_drv = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_count", bus.oRX_COUNT, 0);
        check("glitch_ferr", fe_cyc - fe_base, 0);
        check("glitch_ovr", bus.oOVERRUN, 0);
        send_rx(8'hA7, 1'b1);
        check("post_glitch_count", bus.oRX_COUNT, 1);
        check("post_glitch_word", bus.oRX_DATA, 8'hA7);

        // reset during TX data bit 3
        send_tx(8'hC3);
        repeat (70) @(negedge clk);
        check("mid_tx_bit3", bus.oTX, 0);
        check("mid_tx_busy", bus.oTX_READY, 0);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_tx", bus.oTX, 1);
        check("mid_rst_ready", bus.oTX_READY, 1);
        check("mid_rst_count", bus.oRX_COUNT, 0);
        check("mid_rst_valid", bus.oRX_VALID, 0);
        check("mid_rst_data", bus.oRX_DATA, 0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("post_rst_line", bus.oTX, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
